// File: rtl/pe_drain_fp8.sv
// rtl/pe_drain_fp8.sv - snapshot PE accumulators, requantize to FP8 E4M3, stream row-major
module pe_drain_fp8 #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int FRAC_BITS = 7,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ROWS*COLS*16-1:0] acc_in,
  output logic                   pe_clear,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic [RW-1:0]          out_row,
  output logic [CW-1:0]          out_col,
  output logic                   out_last,
  output logic                   done
);
  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N + 1);

  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [N*16-1:0] snap;
  logic [IW-1:0]   idx;
  logic [RW-1:0]   ld_row;
  logic [CW-1:0]   ld_col;

  logic            s1_valid, s1_sign, s1_last;
  logic [16:0]     s1_mag;
  logic [4:0]      s1_lead;
  logic [RW-1:0]   s1_row;
  logic [CW-1:0]   s1_col;

  logic            adv, take, fire_last, s1_load;
  logic [15:0]     src_word;
  logic [IW-1:0]   src_idx;
  logic [RW-1:0]   src_row, nxt_row;
  logic [CW-1:0]   src_col, nxt_col;
  logic [16:0]     src_mag;
  logic [4:0]      src_lead;

  assign adv       = !out_valid || out_ready;
  assign take      = (state == IDLE) && start;
  assign fire_last = out_valid && out_ready && out_last;
  assign busy      = (state == DRAIN);
  assign s1_load   = take || ((state == DRAIN) && adv && (idx < IW'(N)));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRAIN;
      DRAIN:   if (fire_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Element 0 bypasses the buffer so it sits in S1 the cycle after the snapshot.
  always_comb begin
    src_word = take ? acc_in[15:0] : snap[16*idx +: 16];
    src_idx  = take ? '0 : idx;
    src_row  = take ? '0 : ld_row;
    src_col  = take ? '0 : ld_col;
    if (src_col == CW'(COLS - 1)) begin
      nxt_col = '0;
      nxt_row = src_row + 1'b1;
    end else begin
      nxt_col = src_col + 1'b1;
      nxt_row = src_row;
    end
    src_mag  = src_word[15] ? (~{1'b1, src_word} + 17'd1) : {1'b0, src_word};
    src_lead = 5'd0;
    for (int i = 0; i < 17; i++)
      if (src_mag[i]) src_lead = 5'(i);
  end

  logic signed [6:0] e;
  logic [15:0]       norm;
  logic [2:0]        m3;
  logic              g, st, rup;
  logic [3:0]        m4, sub;
  logic [4:0]        ex;
  logic [7:0]        fp8;

  always_comb begin
    e    = $signed({2'b00, s1_lead}) - $signed(7'(FRAC_BITS));
    norm = 16'(s1_mag << (5'd16 - s1_lead));
    m3   = norm[15:13];
    g    = norm[12];
    st   = |norm[11:0];
    rup  = g & (st | m3[0]);
    m4   = {1'b0, m3} + {3'b000, rup};
    ex   = 5'(e + 7'sd7) + {4'b0000, m4[3]};
    sub  = 4'(s1_mag << (9 - FRAC_BITS));
    fp8  = 8'h00;
    if (s1_mag == 17'd0)
      fp8 = 8'h00;
    else if (e > 7'sd8)
      fp8 = {s1_sign, 7'h7E};
    else if (e < -7'sd6)
      fp8 = sub[3] ? {s1_sign, 4'd1, 3'd0} : {s1_sign, 4'd0, sub[2:0]};
    else if (ex[4] || (ex == 5'd15 && m4[2:0] == 3'd7))
      fp8 = {s1_sign, 7'h7E};
    else
      fp8 = {s1_sign, ex[3:0], m4[2:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      snap      <= '0;
      idx       <= '0;
      ld_row    <= '0;
      ld_col    <= '0;
      pe_clear  <= 1'b0;
      done      <= 1'b0;
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_last   <= 1'b0;
      s1_mag    <= '0;
      s1_lead   <= '0;
      s1_row    <= '0;
      s1_col    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pe_clear <= take;
      done     <= fire_last;
      if (take) snap <= acc_in;
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_sign  <= src_word[15];
        s1_mag   <= src_mag;
        s1_lead  <= src_lead;
        s1_row   <= src_row;
        s1_col   <= src_col;
        s1_last  <= (src_idx == IW'(N - 1));
        idx      <= src_idx + 1'b1;
        ld_row   <= nxt_row;
        ld_col   <= nxt_col;
      end else if (adv) begin
        s1_valid <= 1'b0;
      end
      if (adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= fp8;
          out_row  <= s1_row;
          out_col  <= s1_col;
          out_last <= s1_last;
        end
      end
    end
  end
endmodule

// File: tb/tb_pe_drain_fp8.sv
// tb/tb_pe_drain_fp8.sv - scoreboard bench for pe_drain_fp8 (2x2 FB7, 2x2 FB0, 4x4 FB7)
module tb_pe_drain_fp8;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       last;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] data;
  } beat_t;

  beat_t q_a[$], q_b[$], q_c[$];
  int checks = 0;
  int errors = 0;

  logic rst_a, start_a, ready_a, clr_a, busy_a, valid_a, last_a, done_a;
  logic [63:0] acc_a;
  logic [7:0]  data_a;
  logic [0:0]  row_a, col_a;
  logic rst_b, start_b, ready_b, clr_b, busy_b, valid_b, last_b, done_b;
  logic [63:0] acc_b;
  logic [7:0]  data_b;
  logic [0:0]  row_b, col_b;
  logic rst_c, start_c, ready_c, clr_c, busy_c, valid_c, last_c, done_c;
  logic [255:0] acc_c;
  logic [7:0]   data_c;
  logic [1:0]   row_c, col_c;

  pe_drain_fp8 #(.ROWS(2), .COLS(2), .FRAC_BITS(7)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .acc_in(acc_a), .pe_clear(clr_a), .busy(busy_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a), .out_row(row_a),
    .out_col(col_a), .out_last(last_a), .done(done_a));
  pe_drain_fp8 #(.ROWS(2), .COLS(2), .FRAC_BITS(0)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .acc_in(acc_b), .pe_clear(clr_b), .busy(busy_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b), .out_row(row_b),
    .out_col(col_b), .out_last(last_b), .done(done_b));
  pe_drain_fp8 #(.ROWS(4), .COLS(4), .FRAC_BITS(7)) dut_c (
    .clk(clk), .rst(rst_c), .start(start_c), .acc_in(acc_c), .pe_clear(clr_c), .busy(busy_c),
    .out_valid(valid_c), .out_ready(ready_c), .out_data(data_c), .out_row(row_c),
    .out_col(col_c), .out_last(last_c), .done(done_c));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int which, input logic last, input int row, input int col, input int data);
    beat_t b;
    b = '{last: last, row: 4'(row), col: 4'(col), data: 8'(data)};
    case (which)
      0: q_a.push_back(b);
      1: q_b.push_back(b);
      default: q_c.push_back(b);
    endcase
  endtask

  task automatic mon(input int which, input beat_t got);
    beat_t e;
    int n;
    n = (which == 0) ? q_a.size() : (which == 1) ? q_b.size() : q_c.size();
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL beat%0d: unexpected beat %0h with empty scoreboard", which, got);
    end else begin
      case (which)
        0: e = q_a.pop_front();
        1: e = q_b.pop_front();
        default: e = q_c.pop_front();
      endcase
      chk($sformatf("beat%0d {last,row,col,data}", which), int'(got), int'(e));
    end
  endtask

  always @(negedge clk) if (valid_a && ready_a) mon(0, {last_a, 3'b0, row_a, 3'b0, col_a, data_a});
  always @(negedge clk) if (valid_b && ready_b) mon(1, {last_b, 3'b0, row_b, 3'b0, col_b, data_b});
  always @(negedge clk) if (valid_c && ready_c) mon(2, {last_c, 2'b0, row_c, 2'b0, col_c, data_c});

  task automatic pulse(input int which);
    @(posedge clk); #1;
    case (which)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  task automatic wait_done(input int which);
    logic d;
    d = 1'b0;
    for (int n = 0; n < 300 && !d; n++) begin
      @(negedge clk);
      d = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
    end
    chk($sformatf("done%0d seen", which), int'(d), 1);
  endtask

  localparam logic [7:0] EXP_C [16] = '{8'h38, 8'h40, 8'h44, 8'h48, 8'h4A, 8'h4C, 8'h4E, 8'h50,
                                        8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58};

  task automatic fill_c();
    for (int k = 0; k < 16; k++) acc_c[16*k +: 16] = 16'((k + 1) * 128);
  endtask

  task automatic push_c(input int n);
    for (int k = 0; k < n; k++) push(2, k == 15, k / 4, k % 4, int'(EXP_C[k]));
  endtask

  initial begin
    int dn;
    logic v;
    rst_a = 1; rst_b = 1; rst_c = 1;
    start_a = 0; start_b = 0; start_c = 0;
    ready_a = 1; ready_b = 1; ready_c = 1;
    acc_a = '0; acc_b = '0; acc_c = '0;
    repeat (2) @(posedge clk);
    #1 rst_a = 0; rst_b = 0; rst_c = 0;

    @(negedge clk);
    chk("reset out_valid", int'(valid_a), 0);
    chk("reset busy", int'(busy_a), 0);
    chk("reset pe_clear", int'(clr_a), 0);
    chk("reset done", int'(done_a), 0);
    chk("reset out_data", int'(data_a), 0);
    chk("reset out_last", int'(last_c), 0);

    // 2x2 basic stream with cycle-accurate control checks
    acc_a = {16'h8000, 16'h0000, 16'hFF80, 16'h0080};
    push(0, 0, 0, 0, 'h38); push(0, 0, 0, 1, 'hB8);
    push(0, 0, 1, 0, 'h00); push(0, 1, 1, 1, 'hF8);
    pulse(0);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      chk($sformatf("pe_clear cyc%0d", cyc), int'(clr_a), int'(cyc == 1));
      chk($sformatf("done cyc%0d", cyc), int'(done_a), int'(cyc == 6));
      chk($sformatf("out_valid cyc%0d", cyc), int'(valid_a), int'(cyc >= 2 && cyc <= 5));
      chk($sformatf("busy cyc%0d", cyc), int'(busy_a), int'(cyc <= 5));
      if (cyc >= 2 && cyc <= 5) chk($sformatf("out_last cyc%0d", cyc), int'(last_a), int'(cyc == 5));
    end

    // rounding and subnormal
    acc_a = {16'h0001, 16'h7FFF, 16'h0098, 16'h0088};
    push(0, 0, 0, 0, 'h38); push(0, 0, 0, 1, 'h3A);
    push(0, 0, 1, 0, 'h78); push(0, 1, 1, 1, 'h04);
    pulse(0);
    wait_done(0);

    // saturation with FRAC_BITS=0
    acc_b = {16'd464, 16'd448, 16'hFC18, 16'd1000};
    push(1, 0, 0, 0, 'h7E); push(1, 0, 0, 1, 'hFE);
    push(1, 0, 1, 0, 'h7E); push(1, 1, 1, 1, 'h7E);
    pulse(1);
    wait_done(1);

    // backpressure, ignored second start and post-snapshot acc_in change
    fill_c();
    push_c(16);
    ready_c = 0;
    pulse(2);
    v = 1'b0;
    for (int n = 0; n < 20 && !v; n++) begin
      @(negedge clk);
      v = valid_c;
    end
    chk("valid under stall", int'(v), 1);
    acc_c = {16{16'h1234}};
    pulse(2);
    repeat (5) begin
      @(negedge clk);
      chk("stall out_valid", int'(valid_c), 1);
      chk("stall out_data", int'(data_c), 'h38);
      chk("stall out_row", int'(row_c), 0);
      chk("stall out_col", int'(col_c), 0);
      chk("stall out_last", int'(last_c), 0);
    end
    @(posedge clk); #1 ready_c = 1;
    wait_done(2);
    @(negedge clk);
    chk("stream c drained", q_c.size(), 0);

    // reset mid-drain on beat 3
    fill_c();
    push_c(3);
    pulse(2);
    repeat (4) @(posedge clk);
    #1 rst_c = 1;
    #1;
    chk("rst out_valid", int'(valid_c), 0);
    chk("rst out_data", int'(data_c), 0);
    chk("rst out_row", int'(row_c), 0);
    chk("rst out_col", int'(col_c), 0);
    chk("rst busy", int'(busy_c), 0);
    chk("rst done", int'(done_c), 0);
    @(posedge clk); #1 rst_c = 0;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_c) dn++;
    end
    chk("no done after rst", dn, 0);
    chk("beats before rst", q_c.size(), 0);
    push_c(16);
    pulse(2);
    wait_done(2);
    @(negedge clk);

    chk("scoreboard a empty", q_a.size(), 0);
    chk("scoreboard b empty", q_b.size(), 0);
    chk("scoreboard c empty", q_c.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_drain_fp8.md
# pe_drain_fp8

Output drain and requantizer for the FP8 systolic array. Once a tile has finished, it snapshots the 16-bit signed accumulator word of every PE. It converts each word to FP8 E4M3 in a single shared two-stage pipeline and streams the results out in row-major order with a valid/ready handshake. It also pulses a clear to the array so the next tile can start accumulating while the drain runs.

## Interface
- ROWS, default 4: array rows (1..16).
- COLS, default 4: array columns (1..16).
- FRAC_BITS, default 7: number of fractional bits in an accumulator word (0..9). Accumulator value = signed word × 2^-FRAC_BITS.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to snapshot and drain. Ignored while busy=1.
- acc_in  in  ROWS*COLS*16  flattened PE accumulators. Element i = r*COLS+c sits at bits [16*i +: 16].
- pe_clear  out  1  one-cycle pulse to the array's clear input.
- busy  out  1  high from the snapshot until the final beat is accepted.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the beat when out_valid & out_ready.
- out_data  out  8  FP8 E4M3 result: sign, exp[3:0] with bias 7, mant[2:0].
- out_row  out  max(1,clog2(ROWS))  row of the current beat.
- out_col  out  max(1,clog2(COLS))  column of the current beat.
- out_last  out  1  high on the beat for element ROWS*COLS-1.
- done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- Reset values: every output is 0, the FSM is in IDLE, and the snapshot buffer is cleared.
- FSM states:
  - IDLE → DRAIN when start=1. At that edge all of acc_in is loaded into the snapshot buffer and the element counter is set to 0.
  - DRAIN → IDLE at the edge where the beat with out_last=1 is accepted.
- pe_clear is registered. It is high for exactly the one cycle after the snapshot edge.
- Pipeline stage 1 (S1): selects buffer[idx] and computes sign and magnitude (17-bit, so -32768 gives magnitude 32768). It also computes the leading-one position. S1 then increments idx.
- Pipeline stage 2 (S2): rounds and packs the value into out_data, out_row, out_col and out_last.
- Stall rule: both stages advance only when !out_valid | out_ready. When stalled, every output holds its value.
- S1 stops loading once idx = ROWS*COLS. No beat is skipped or duplicated.
- Conversion rules, with e = leading-one position - FRAC_BITS:
  - Magnitude 0 gives 0x00 (no negative zero).
  - Normal case (-6 ≤ e ≤ 8): exp field = e+7. Mantissa = the 3 bits below the leading one, rounded to nearest with ties to even. A mantissa carry increments exp.
  - Subnormal case (e < -6): exp field = 0, mant = round-half-even(mag × 2^(9-FRAC_BITS)). If that rounds to 8, the result becomes exp=1, mant=0.
  - Saturation: if e > 8, or the rounded result exceeds 448 (exp 15 with mant 7 is the NaN code), output sign|0x7E. NaN is never produced.
- start while busy: ignored, with no effect on the buffer or counters. acc_in changes after the snapshot are also ignored.
- rst mid-drain: the pipeline is flushed immediately. No done pulse is issued, and a fresh start is required.

## Timing
- Cycle 0: start is sampled high and the snapshot is loaded. busy rises after edge 0.
- Cycle 1: pe_clear=1, and S1 holds element 0.
- Cycle 2: out_valid=1 with element 0.
- With out_ready held at 1: element k appears in cycle 2+k, and out_last appears in cycle 1+ROWS*COLS.
- done=1 and busy=0 in the cycle after the last accepted beat.
- A new start is accepted in the same cycle that done is high.
- Throughput: 1 beat per cycle. Latency: 2 cycles from snapshot to the first beat.

## Test plan
- FRAC_BITS=7, 2×2 array with acc = {0x0080, 0xFF80, 0x0000, 0x8000} and out_ready=1 → in cycles 2..5, out_data = 0x38, 0xB8, 0x00, 0xF8. Row/col = (0,0),(0,1),(1,0),(1,1). out_last=1 only on the 4th beat. done=1 in cycle 6. pe_clear=1 only in cycle 1.
- Rounding with FRAC_BITS=7: 0x0088 → 0x38 (tie goes even). 0x0098 → 0x3A. 0x7FFF → 0x78 (the carry bumps exp). 0x0001 → 0x04 (subnormal).
- Saturation with FRAC_BITS=0: 1000 → 0x7E, -1000 → 0xFE, 448 → 0x7E, 464 → 0x7E (never 0x7F).
- Backpressure: hold out_ready=0 for 5 cycles while out_valid=1 → out_data, out_row, out_col and out_last stay stable. On release all 16 beats of a 4×4 array arrive in order with none dropped or duplicated.
- A second start during DRAIN, with acc_in changed after the snapshot → both are ignored, and the stream reflects only the snapshot values.
- Assert rst at beat 3 of 16 → all outputs are 0 in the same cycle and no done pulse appears. After a new start, the stream begins again from (0,0).
